// File: rtl/div_pkg.sv
// Shared types and constants for the serial non-restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    // All ones, truncated to the instance width at the point of use.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_DIVISOR,
        ITERATE,
        CORRECT,
        OUT_Q,
        OUT_R
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; serves as abs() for operands and sign restore for results.
// Only built when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module div_sign_fix #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule
`endif

// File: rtl/nrdiv_serial.sv
// Serial non-restoring divider: dividend/divisor loaded over two cycles, one quotient bit per clock,
// quotient then remainder returned on outbus. Define DIV_SIGNED_EN for signed two's-complement operands.
module nrdiv_serial
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] inbus,
    output logic             done,
    output logic [WIDTH-1:0] outbus,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_d;
    logic [WIDTH-1:0] outbus_d;
    logic             dbz_d;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] quot_res, rem_res;

    // Modular WIDTH+1 arithmetic is exact: every step result lies in [-D, D).
    assign p_sh    = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign p_step  = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
    assign rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic dvd_neg_q, dvd_neg_d;
    logic dvs_neg_q, dvs_neg_d;

    div_sign_fix #(.WIDTH(WIDTH)) u_dvd_abs (.a(inbus),   .neg(inbus[WIDTH-1]),       .y(dvd_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_dvs_abs (.a(inbus),   .neg(inbus[WIDTH-1]),       .y(dvs_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_q_fix   (.a(q_q),     .neg(dvd_neg_q ^ dvs_neg_q), .y(quot_res));
    div_sign_fix #(.WIDTH(WIDTH)) u_r_fix   (.a(rem_mag), .neg(dvd_neg_q),            .y(rem_res));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
        end else begin
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
        end
    end

    always_comb begin
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        if (state_q == IDLE && enable) dvd_neg_d = inbus[WIDTH-1];
        if (state_q == LOAD_DIVISOR)   dvs_neg_d = inbus[WIDTH-1];
    end
`else
    assign dvd_mag  = inbus;
    assign dvs_mag  = inbus;
    assign quot_res = q_q;
    assign rem_res  = rem_mag;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_raw_q   <= '0;
            q_q         <= '0;
            d_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            done        <= 1'b0;
            outbus      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_raw_q   <= dvd_raw_d;
            q_q         <= q_d;
            d_q         <= d_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            done        <= done_d;
            outbus      <= outbus_d;
            div_by_zero <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dvd_raw_d = dvd_raw_q;
        q_d       = q_q;
        d_d       = d_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        outbus_d  = '0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    dvd_raw_d = inbus;
                    q_d       = dvd_mag;
                    state_d   = LOAD_DIVISOR;
                end
            end
            LOAD_DIVISOR: begin
                d_d     = dvs_mag;
                p_d     = '0;
                cnt_d   = '0;
                state_d = ITERATE;
            end
            ITERATE: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = CORRECT;
            end
            CORRECT: begin
                done_d = 1'b1;
                if (d_q == '0) begin
                    outbus_d = WIDTH'(DBZ_QUOTIENT);
                    rem_d    = dvd_raw_q;
                    dbz_d    = 1'b1;
                end else begin
                    outbus_d = quot_res;
                    rem_d    = rem_res;
                end
                state_d = OUT_Q;
            end
            OUT_Q: begin
                done_d   = 1'b1;
                outbus_d = rem_q;
                dbz_d    = div_by_zero;
                state_d  = OUT_R;
            end
            OUT_R: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nrdiv_serial.sv
// Directed bench for nrdiv_serial with a scoreboard of expected quotient/remainder/div_by_zero.
module tb_nrdiv_serial;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] inbus;
    logic       done;
    logic [7:0] outbus;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t scb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    nrdiv_serial #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .inbus       (inbus),
        .done        (done),
        .outbus      (outbus),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sd;
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            e.q = 8'(sa / sd);
            e.r = 8'(sa % sd);
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge after E12.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit pulse);
        exp_t e;
        enable = 1'b1;
        inbus  = a;
        scb.push_back(model(a, b));
        @(negedge clk);
        enable = 1'b0;
        inbus  = b;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (pulse && k == 3) begin
                enable = 1'b1;
                inbus  = 8'h55;
            end else begin
                enable = 1'b0;
                inbus  = 8'h00;
            end
        end
        check("pre_done", 32'(done), 32'd0);
        @(negedge clk);
        if (scb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = scb.pop_front();
        end
        check("q_done", 32'(done), 32'd1);
        check("quotient", 32'(outbus), 32'(e.q));
        check("q_dbz", 32'(div_by_zero), 32'(e.dbz));
        @(negedge clk);
        check("r_done", 32'(done), 32'd1);
        check("remainder", 32'(outbus), 32'(e.r));
        check("r_dbz", 32'(div_by_zero), 32'(e.dbz));
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_outbus", 32'(outbus), 32'd0);
        check("idle_dbz", 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        inbus  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outbus", 32'(outbus), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd7, 1'b0);
        run_op(8'd25, 8'd0, 1'b0);
        run_op(8'hFD, 8'd2, 1'b0);
        run_op(8'd200, 8'd13, 1'b0);
        run_op(8'd255, 8'd1, 1'b0);
        run_op(8'd7, 8'd9, 1'b0);
        run_op(8'd0, 8'd5, 1'b0);
        run_op(8'd100, 8'd7, 1'b1);
        run_op(8'd255, 8'd255, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'hF9, 8'd2, 1'b0);
        run_op(8'd7, 8'hFE, 1'b0);
`endif

        // Abort an operation with reset at E6.
        enable = 1'b1;
        inbus  = 8'd100;
        @(negedge clk);
        enable = 1'b0;
        inbus  = 8'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            inbus = 8'h00;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_outbus", 32'(outbus), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_quiet", 32'(done), 32'd0);
        end
        run_op(8'd9, 8'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nrdiv_serial.md
Name: nrdiv_serial

Overview:
- Sequential non-restoring integer divider; the inverse operation to the booth4 multiplier in multiplication_devices.
- Uses the same narrow handshake: enable, an 8-bit inbus, done, and an 8-bit outbus.
- Operands are loaded serially over two cycles. The block iterates one quotient bit per clock, then returns the quotient and the remainder on outbus in two consecutive cycles.

Parameters:
- WIDTH, 8, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  start strobe; sampled only in IDLE; inbus carries the dividend in the same cycle
- inbus  input  WIDTH  dividend in the enable cycle, divisor in the following cycle
- done  output  1  high for exactly two cycles: the quotient cycle, then the remainder cycle
- outbus  output  WIDTH  quotient, then remainder; 0 otherwise
- div_by_zero  output  1  high together with done when the divisor was 0

Behaviour:
- Interface is fixed as decided: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values (asynchronous): state=IDLE, done=0, outbus=0, div_by_zero=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately with no output.
- States: IDLE, LOAD_DIVISOR, ITERATE, CORRECT, OUT_Q, OUT_R.
- Timing is counted in rising edges, with E0 the edge at which enable=1 is seen in IDLE:
  - E0: latch dividend from inbus; go to LOAD_DIVISOR.
  - E1: latch divisor from inbus; clear partial remainder P (WIDTH+1 bits, signed) and counter; go to ITERATE.
  - E2..E(WIDTH+1): one non-restoring step per edge.
    - Shift {P,Q} left by 1.
    - If P≥0 then P=P−D, else P=P+D.
    - Q[0] = ~P_new[WIDTH].
    - After WIDTH steps go to CORRECT.
  - E(WIDTH+2): if P<0 then P=P+D. Apply sign fixes. Register outbus=quotient, done=1, div_by_zero as applicable. Go to OUT_Q.
  - E(WIDTH+3): outbus=remainder, done stays 1; go to OUT_R.
  - E(WIDTH+4): outbus=0, done=0, div_by_zero=0; go to IDLE.
- Latency for WIDTH=8: quotient visible after E10, remainder after E11, idle after E12. A new enable is accepted at the edge following E12.
- Enable outside IDLE is ignored, including enable held high throughout. Enable held high into IDLE starts a new operation.
- Divide by zero: iterations still run, but results are forced to quotient=all ones and remainder=dividend (as loaded), with div_by_zero=1 during both done cycles.
- Arithmetic is unsigned unless DIV_SIGNED_EN is defined.
- Identities: dividend = quotient×divisor + remainder, and |remainder| < |divisor|, for all non-zero divisors except the signed-overflow case.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined (signed two's-complement operands):
  - Magnitudes are taken at load.
  - Quotient is negated if the operand signs differ, so division truncates toward zero.
  - Remainder takes the dividend's sign.
  - Overflow case (−2^(WIDTH−1)) / (−1): quotient=8'h80 (wraps), remainder=0, div_by_zero=0.
  - Divide-by-zero result is the same as in the unsigned build.
- Undefined: operands are unsigned magnitudes and no sign logic is synthesised.

Decomposition:
- Package div_pkg: state enum typedef (div_state_t), default WIDTH constant, divide-by-zero quotient constant (all ones).
- One sub-module, div_sign_fix: combinational conditional negate/abs, instantiated for operand magnitude and result correction. Present only under DIV_SIGNED_EN.

Test Plan:
- Unsigned 100 / 7 -> quotient 14 after E10, remainder 2 after E11; done high for exactly 2 cycles, then outbus=0.
- 25 / 0 -> quotient 8'hFF, remainder 25, div_by_zero=1 in both done cycles.
- Unsigned build, 8'hFD / 2 -> 126 r 1. DIV_SIGNED_EN build, same operands (−3 / 2) -> quotient 8'hFF (−1), remainder 8'hFF (−1).
- DIV_SIGNED_EN: −128 / −1 -> quotient 8'h80, remainder 0; also −7 / 2 -> 8'hFD, 8'hFF.
- Pulse enable again at E4 with different inbus -> ignored; results match the first operation. Re-enable after E12 -> a second operation completes correctly.
- Drop rst_n at E6 -> done/outbus 0 immediately, state IDLE; a subsequent 9 / 3 -> 3 r 0.
